sdram_req_responder: RTL and testbench

- Memory-side end of the customLogicTLD SDRAM request interface.
- Accepts pulsed read/write requests and returns read data with a one-cycle `sdram_datareadvalid` pulse.
- Converts requests into Avalon-MM master transactions toward the SDRAM controller, including waitrequest handling.
- Buffers posted requests in a small in-order command FIFO, so back-to-back `sdram_write_en` bursts from customLogicTLD are absorbed without loss.

---
 rtl/sdram_req_responder.sv | 146 ++++++++++++++
 tb/tb_sdram_req_responder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_req_responder.sv
// Memory-side end of the customLogicTLD SDRAM request interface: pulsed requests are queued
// in an in-order command FIFO and replayed as single-outstanding Avalon-MM transactions.
module sdram_req_responder #(
  parameter int          CMD_DEPTH = 4,
  parameter logic [25:0] ADDR_BASE = 26'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdram_read_en,
  input  logic        sdram_write_en,
  input  logic [25:0] address_sdram,
  input  logic [31:0] writeData_sdram,
  output logic [31:0] data_sdram,
  output logic        sdram_datareadvalid,
  output logic [25:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        overflow_err,
  output logic        protocol_err
);

  // state   | meaning
  // IDLE    | no transaction; pops the FIFO head unless in the post-transaction bubble
  // ISSUE   | strobe asserted, all avm outputs held until waitrequest drops
  // WAIT_RD | read accepted by the controller, waiting for readdatavalid
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  localparam int          PW       = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(CMD_DEPTH);
  localparam int          CW       = 1 + 26 + 32;

  logic [CW-1:0] fifo_mem [CMD_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [CW-1:0] head;
  logic          req, push, pop, full, empty;

  state_t        state_q, state_d;
  logic          bubble_q, bubble_d;
  logic          rd_d, wr_d, dvalid_d;
  logic [25:0]   addr_d;
  logic [31:0]   wdata_d, rdata_d;
  logic [3:0]    be_d;

  assign req   = sdram_read_en | sdram_write_en;
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign pop   = (state_q == IDLE) && !empty && !bubble_q;
  assign push  = req && (!full || pop);
  assign head  = fifo_mem[rd_ptr];
  assign busy  = !empty || (state_q != IDLE);

  // On simultaneous rd/wr the write wins: is_write is simply sdram_write_en.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {sdram_write_en, address_sdram + ADDR_BASE, writeData_sdram};
  end

  always_comb begin
    state_d  = state_q;
    bubble_d = 1'b0;
    rd_d     = avm_read;
    wr_d     = avm_write;
    addr_d   = avm_address;
    wdata_d  = avm_writedata;
    be_d     = avm_byteenable;
    rdata_d  = data_sdram;
    dvalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          wr_d    = head[CW-1];
          rd_d    = !head[CW-1];
          addr_d  = head[57:32];
          wdata_d = head[31:0];
          be_d    = 4'hF;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!avm_waitrequest) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          be_d = 4'h0;
          if (avm_write) begin
            state_d  = IDLE;
            bubble_d = 1'b1;
          end else begin
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (avm_readdatavalid) begin
          rdata_d  = avm_readdata;
          dvalid_d = 1'b1;
          state_d  = IDLE;
          bubble_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= IDLE;
      bubble_q            <= 1'b0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      avm_read            <= 1'b0;
      avm_write           <= 1'b0;
      avm_address         <= '0;
      avm_writedata       <= '0;
      avm_byteenable      <= '0;
      data_sdram          <= '0;
      sdram_datareadvalid <= 1'b0;
      overflow_err        <= 1'b0;
      protocol_err        <= 1'b0;
    end else begin
      state_q             <= state_d;
      bubble_q            <= bubble_d;
      avm_read            <= rd_d;
      avm_write           <= wr_d;
      avm_address         <= addr_d;
      avm_writedata       <= wdata_d;
      avm_byteenable      <= be_d;
      data_sdram          <= rdata_d;
      sdram_datareadvalid <= dvalid_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      if (req && !push) overflow_err <= 1'b1;
      if ((sdram_read_en && sdram_write_en) || (avm_readdatavalid && state_q != WAIT_RD))
        protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_req_responder.sv
// Bench for sdram_req_responder: cycle-stepped Avalon slave model plus a request-level
// scoreboard (command order, memory contents, FIFO occupancy, sticky flags).
module tb_sdram_req_responder;
  localparam int          DEPTH = 4;
  localparam logic [25:0] BASE  = 26'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sdram_read_en = 1'b0, sdram_write_en = 1'b0;
  logic [25:0] address_sdram = '0;
  logic [31:0] writeData_sdram = '0;
  logic [31:0] data_sdram;
  logic        sdram_datareadvalid;
  logic [25:0] avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        busy, overflow_err, protocol_err;

  always #5 clk = ~clk;

  sdram_req_responder #(.CMD_DEPTH(DEPTH), .ADDR_BASE(BASE)) dut (
    .clk(clk), .rst(rst),
    .sdram_read_en(sdram_read_en), .sdram_write_en(sdram_write_en),
    .address_sdram(address_sdram), .writeData_sdram(writeData_sdram),
    .data_sdram(data_sdram), .sdram_datareadvalid(sdram_datareadvalid),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy(busy), .overflow_err(overflow_err), .protocol_err(protocol_err)
  );

  typedef struct { bit wr; logic [25:0] addr; logic [31:0] data; } cmd_t;

  cmd_t        cmd_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] ref_mem [logic [25:0]];
  logic [31:0] slv_mem [logic [25:0]];

  int checks = 0, errors = 0, cyc = 0;
  int cnt = 0;
  bit wait_rd = 0, ovf_exp = 0, prot_exp = 0, resp_exp = 0;
  logic [31:0] data_exp = '0;
  bit last_rd = 0, last_wr = 0, last_rst = 1, last_rdv = 0, last_acc_rd = 0, strobe_prev = 0;
  logic [25:0] last_a = '0;
  logic [31:0] last_d = '0;
  bit in_txn = 0, pend_active = 0;
  int stall_left = 0, pend_cnt = 0, stall_cfg = 0, lat_cfg = 1;
  logic [31:0] pend_data = '0;
  logic [63:0] snap = '0;
  int txn_count = 0, wr_count = 0, resp_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_get(input logic [25:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] slv_get(input logic [25:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : 32'h0;
  endfunction

  task automatic preload(input logic [25:0] a, input logic [31:0] d);
    logic [25:0] pa;
    pa = a + BASE;
    ref_mem[pa] = d;
    slv_mem[pa] = d;
  endtask

  // One clock: observe last edge, update model, check, then drive the next edge's inputs.
  task automatic cycle(input bit rd, input bit wr, input logic [25:0] a, input logic [31:0] d,
                       input bit r);
    bit strobe, pop_now, acc;
    cmd_t c;
    logic [25:0] pa;
    @(negedge clk);
    cyc++;
    strobe  = (avm_read === 1'b1) || (avm_write === 1'b1);
    pop_now = strobe && !strobe_prev;
    if (pop_now) begin
      chk("pop_nonempty", cmd_q.size() != 0, 1);
      if (cmd_q.size() != 0) begin
        c = cmd_q.pop_front();
        chk("cmd_is_write", avm_write, c.wr);
        chk("cmd_addr", avm_address, c.addr);
        if (c.wr) chk("cmd_wdata", avm_writedata, c.data);
      end
    end
    strobe_prev = strobe;
    resp_exp = 0;
    if (last_rst) begin
      cnt = 0; cmd_q.delete(); exp_rd_q.delete();
      wait_rd = 0; ovf_exp = 0; prot_exp = 0; data_exp = '0;
    end else begin
      if (last_rdv) begin
        if (wait_rd) begin
          wait_rd  = 0;
          resp_exp = 1;
          if (exp_rd_q.size() != 0) data_exp = exp_rd_q.pop_front();
          else chk("resp_unexpected", 1, 0);
        end else prot_exp = 1;
      end
      if (last_acc_rd) wait_rd = 1;
      if (last_rd && last_wr) prot_exp = 1;
      if (last_rd || last_wr) begin
        acc = (cnt < DEPTH) || pop_now;
        if (acc) begin
          pa = last_a + BASE;
          c.wr = last_wr; c.addr = pa; c.data = last_d;
          cmd_q.push_back(c);
          if (last_wr) ref_mem[pa] = last_d;
          else exp_rd_q.push_back(ref_get(pa));
          cnt++;
        end else ovf_exp = 1;
      end
      if (pop_now) cnt--;
    end

    chk("busy", busy, (cnt > 0) || strobe || wait_rd);
    chk("overflow_err", overflow_err, ovf_exp);
    chk("protocol_err", protocol_err, prot_exp);
    chk("datareadvalid", sdram_datareadvalid, resp_exp);
    chk("data_sdram", data_sdram, data_exp);
    chk("byteenable", avm_byteenable, strobe ? 4'hF : 4'h0);
    chk("rd_wr_excl", avm_read & avm_write, 0);
    if (sdram_datareadvalid === 1'b1) resp_cyc = cyc;

    avm_readdatavalid = 1'b0;
    avm_readdata      = $urandom;
    last_rdv          = 0;
    if (pend_active) begin
      pend_cnt--;
      if (pend_cnt <= 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = pend_data;
        pend_active       = 0;
        last_rdv          = 1;
      end
    end
    last_acc_rd     = 0;
    avm_waitrequest = 1'($urandom_range(0, 1));
    if (strobe) begin
      if (!in_txn) begin
        in_txn     = 1;
        stall_left = (stall_cfg < 0) ? int'($urandom_range(0, 2)) : stall_cfg;
        snap       = {avm_read, avm_write, avm_address, avm_writedata, avm_byteenable};
      end else begin
        chk("hold_stable", {avm_read, avm_write, avm_address, avm_writedata, avm_byteenable}, snap);
      end
      if (stall_left > 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
      end else begin
        avm_waitrequest = 1'b0;
        in_txn = 0;
        txn_count++;
        if (avm_write) begin
          slv_mem[avm_address] = avm_writedata;
          wr_count++;
        end else begin
          pend_active = 1;
          pend_cnt    = (lat_cfg < 0) ? int'($urandom_range(1, 3)) : lat_cfg;
          pend_data   = slv_get(avm_address);
          last_acc_rd = 1;
        end
      end
    end

    sdram_read_en   = rd;
    sdram_write_en  = wr;
    address_sdram   = a;
    writeData_sdram = d;
    rst             = r;
    last_rd = rd; last_wr = wr; last_a = a; last_d = d; last_rst = r;
    if (r) in_txn = 0;
  endtask

  task automatic quiet(input int maxc);
    int n;
    n = 0;
    do begin
      cycle(0, 0, '0, '0, 0);
      n++;
    end while ((busy || pend_active) && n < maxc);
    chk("quiet_timeout", n < maxc, 1);
    cycle(0, 0, '0, '0, 0);
    cycle(0, 0, '0, '0, 0);
  endtask

  task automatic do_reset();
    ref_mem.delete();
    slv_mem.delete();
    pend_active = 0;
    stall_cfg = 0;
    lat_cfg = 1;
    cycle(0, 0, '0, '0, 1);
    cycle(0, 0, '0, '0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, n, t0, w0;
    logic [25:0] a;

    do_reset();
    chk("reset_outputs", {avm_read, avm_write, avm_address, avm_byteenable, sdram_datareadvalid,
                          busy, overflow_err, protocol_err}, 0);

    // single read, minimum latency
    preload(26'h10, 32'hDEADBEEF);
    cycle(1, 0, 26'h10, '0, 0);
    rc = cyc;
    quiet(50);
    chk("single_rd_latency", resp_cyc - rc, 4);
    chk("single_rd_data", data_sdram, 32'hDEADBEEF);

    // write burst absorbed by the FIFO, 3 cycles per write
    w0 = wr_count;
    for (int i = 0; i < 4; i++) cycle(0, 1, 26'(i), 32'h11111111 * (i + 1), 0);
    rc = cyc - 3;
    n = 0;
    do begin cycle(0, 0, '0, '0, 0); n++; end while (busy && n < 40);
    chk("wr_turnaround", cyc - rc, 12);
    chk("burst_writes", wr_count - w0, 4);
    chk("burst_mem3", slv_get(26'h3 + BASE), 32'h44444444);
    quiet(20);

    // waitrequest stall of 5 cycles
    preload(26'h20, 32'h0BADF00D);
    stall_cfg = 5;
    t0 = txn_count;
    cycle(1, 0, 26'h20, '0, 0);
    rc = cyc;
    quiet(50);
    stall_cfg = 0;
    chk("stall_rd_latency", resp_cyc - rc, 9);
    chk("stall_one_txn", txn_count - t0, 1);

    // write then read same address, offset applied
    cycle(0, 1, 26'h7, 32'hCAFEF00D, 0);
    cycle(1, 0, 26'h7, '0, 0);
    quiet(50);
    chk("raw_data", data_sdram, 32'hCAFEF00D);
    chk("raw_mem", slv_get(26'h107), 32'hCAFEF00D);

    // randomized traffic, including addresses that wrap past 2^26 after the offset
    stall_cfg = -1;
    lat_cfg = -1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 35) begin
        a = ($urandom_range(0, 7) == 0) ? 26'h3FFFFFF - 26'($urandom_range(0, 3)) * 26'h80
                                        : 26'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) cycle(0, 1, a, $urandom, 0);
        else cycle(1, 0, a, $urandom, 0);
      end else cycle(0, 0, '0, '0, 0);
    end
    quiet(100);

    // overflow with waitrequest held high on the first write
    do_reset();
    stall_cfg = 20;
    w0 = wr_count;
    for (int i = 0; i < 6; i++) cycle(0, 1, 26'(i), 32'hA0000000 + i, 0);
    stall_cfg = 0;
    cycle(0, 0, '0, '0, 0);
    chk("ovf_set", overflow_err, 1);
    quiet(200);
    chk("ovf_writes", wr_count - w0, 5);
    chk("ovf_dropped_mem", slv_get(26'h5 + BASE), 0);

    // simultaneous rd/wr: only the write goes out
    do_reset();
    t0 = txn_count;
    w0 = wr_count;
    cycle(1, 1, 26'h3, 32'h55AA55AA, 0);
    quiet(50);
    chk("rdwr_prot", protocol_err, 1);
    chk("rdwr_one_txn", txn_count - t0, 1);
    chk("rdwr_is_write", wr_count - w0, 1);

    // reset while in WAIT_RD; late readdatavalid becomes stray
    do_reset();
    lat_cfg = 4;
    cycle(1, 0, 26'h5, '0, 0);
    n = 0;
    do begin cycle(0, 0, '0, '0, 0); n++; end while (!wait_rd && n < 20);
    chk("reach_wait_rd", wait_rd, 1);
    cycle(0, 0, '0, '0, 1);
    cycle(0, 0, '0, '0, 0);
    chk("rst_outs_a", {data_sdram, avm_writedata}, 0);
    chk("rst_outs_b", {avm_address, avm_read, avm_write, avm_byteenable, sdram_datareadvalid,
                       busy, overflow_err, protocol_err}, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, '0, '0, 0);
    chk("stray_prot", protocol_err, 1);
    chk("stray_ovf", overflow_err, 0);
    chk("stray_no_data", data_sdram, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
